// File: rtl/ball_pkg.sv
// ball_pkg: shared types and constants for the pong ball sprite.
// Holds default screen size, FSM states, direction type and hit_edge bit map.
package ball_pkg;

   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;

   // Internal compare width: wide enough that pos+step never wraps.
   localparam int CW = 11;
   // Step register width.
   localparam int SW = 8;

   typedef enum logic [1:0] {
      SERVE = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   typedef enum logic {
      DIR_POS = 1'b0,
      DIR_NEG = 1'b1
   } dir_t;

   // hit_edge = {top, bottom, left, right}
   localparam int HIT_TOP   = 3;
   localparam int HIT_BOT   = 2;
   localparam int HIT_LEFT  = 1;
   localparam int HIT_RIGHT = 0;

endpackage

// File: rtl/ball_motion_render_if.sv
// ball_motion_render_if: raster-in / ball-out bus of the ball sprite.
// master = raster source + game logic, slave = ball_motion_render.
interface ball_motion_render_if;

   logic       o_active;
   logic [9:0] o_x;
   logic [8:0] o_y;
   logic       color;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic [3:0] hit_edge;

   modport master (
      output o_active, o_x, o_y,
      input  color, ball_x, ball_y, hit_edge
   );

   modport slave (
      input  o_active, o_x, o_y,
      output color, ball_x, ball_y, hit_edge
   );

endinterface

// File: rtl/ball_axis_step.sv
// ball_axis_step: one axis of ball motion (position, direction, step, bounce).
// Ports: clk_in, i_rst, i_serve (reload), i_move (do one step),
//        o_pos (left/top edge), o_hit_lo / o_hit_hi (registered edge pulses).
// Optional macro BALL_SPEEDUP_EN: each bounce raises the step up to STEP_MAX.
module ball_axis_step
   import ball_pkg::*;
#(
   parameter int LIMIT    = 640,
   parameter int SIZE     = 8,
   parameter int INIT     = 0,
   parameter int STEP0    = 1,
   parameter int STEP_MAX = 8,
   parameter int PW       = 10
) (
   input  logic          clk_in,
   input  logic          i_rst,
   input  logic          i_serve,
   input  logic          i_move,
   output logic [PW-1:0] o_pos,
   output logic          o_hit_lo,
   output logic          o_hit_hi
);

`ifdef BALL_SPEEDUP_EN
   localparam logic SPEEDUP = 1'b1;
`else
   localparam logic SPEEDUP = 1'b0;
`endif

   localparam logic [CW-1:0] HI_LIM    = CW'(LIMIT - SIZE);
   localparam logic [PW-1:0] POS_INIT  = PW'(INIT);
   localparam logic [SW-1:0] STEP_INIT = SW'(STEP0);
   localparam logic [SW-1:0] STEP_LIM  = SW'(STEP_MAX);

   logic [PW-1:0] r_pos;
   dir_t          r_dir;
   logic [SW-1:0] r_step;
   logic          r_hit_lo;
   logic          r_hit_hi;

   logic [CW-1:0] w_pos_ext;
   logic [CW-1:0] w_step_ext;
   logic [CW-1:0] w_sum;
   logic [CW-1:0] w_diff;
   logic          w_over;
   logic          w_under;
   logic          w_hit;

   assign w_pos_ext  = CW'(r_pos);
   assign w_step_ext = CW'(r_step);
   assign w_sum      = w_pos_ext + w_step_ext;
   assign w_diff     = w_pos_ext - w_step_ext;
   assign w_over     = w_sum > HI_LIM;
   assign w_under    = w_pos_ext < w_step_ext;
   assign w_hit      = (r_dir == DIR_POS) ? w_over : w_under;

   always_ff @(posedge clk_in) begin
      if (i_rst) begin
         r_pos    <= POS_INIT;
         r_dir    <= DIR_POS;
         r_step   <= STEP_INIT;
         r_hit_lo <= 1'b0;
         r_hit_hi <= 1'b0;
      end else begin
         r_hit_lo <= 1'b0;
         r_hit_hi <= 1'b0;
         if (i_serve) begin
            // direction survives a serve so play alternates naturally
            r_pos  <= POS_INIT;
            r_step <= STEP_INIT;
         end else if (i_move) begin
            if (r_dir == DIR_POS) begin
               if (w_over) begin
                  r_pos    <= PW'(HI_LIM);
                  r_dir    <= DIR_NEG;
                  r_hit_hi <= 1'b1;
               end else begin
                  r_pos <= PW'(w_sum);
               end
            end else begin
               if (w_under) begin
                  r_pos    <= '0;
                  r_dir    <= DIR_POS;
                  r_hit_lo <= 1'b1;
               end else begin
                  r_pos <= PW'(w_diff);
               end
            end
            // bounce test above used the old step; bump afterwards
            if (SPEEDUP && w_hit && (r_step < STEP_LIM))
               r_step <= r_step + SW'(1);
         end
      end
   end

   assign o_pos    = r_pos;
   assign o_hit_lo = r_hit_lo;
   assign o_hit_hi = r_hit_hi;

endmodule

// File: rtl/ball_motion_render.sv
// ball_motion_render: pong ball sprite - serve delay, per-frame motion,
// four-edge bounce and registered pixel-on flag for the colour mux.
// Ports: clk_in, i_rst (sync, active-high), i_enable (0 = pause),
//        i_serve (re-centre), bus (ball_motion_render_if.slave:
//        o_active/o_x/o_y in; color/ball_x/ball_y/hit_edge out).
// Optional macro BALL_SPEEDUP_EN (in ball_axis_step): bounce speed-up.
module ball_motion_render
   import ball_pkg::*;
#(
   parameter int H_RES        = H_RES_DEF,
   parameter int V_RES        = V_RES_DEF,
   parameter int BALL_W       = 8,
   parameter int BALL_H       = 8,
   parameter int X_INIT       = 260,
   parameter int Y_INIT       = 300,
   parameter int STEP_X       = 5,
   parameter int STEP_Y       = 3,
   parameter int STEP_MAX     = 8,
   parameter int FRAME_DIV    = 1,
   parameter int SERVE_FRAMES = 60
) (
   input  logic                 clk_in,
   input  logic                 i_rst,
   input  logic                 i_enable,
   input  logic                 i_serve,
   ball_motion_render_if.slave  bus
);

   localparam logic [9:0]    X_LAST   = 10'(H_RES - 1);
   localparam logic [8:0]    Y_LAST   = 9'(V_RES - 1);
   localparam logic [15:0]   SRV_LAST = 16'(SERVE_FRAMES - 1);
   localparam logic [15:0]   DIV_LAST = 16'(FRAME_DIV - 1);
   localparam logic [CW-1:0] BW_M1    = CW'(BALL_W - 1);
   localparam logic [CW-1:0] BH_M1    = CW'(BALL_H - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_srv_cnt;
   logic [15:0] w_srv_nxt;
   logic [15:0] r_div_cnt;
   logic [15:0] w_div_nxt;
   logic        w_move;
   logic        r_corner_d;
   logic        w_corner;
   logic        w_eof;
   logic        r_color;

   logic [9:0]  w_ball_x;
   logic [8:0]  w_ball_y;
   logic        w_hit_l;
   logic        w_hit_r;
   logic        w_hit_t;
   logic        w_hit_b;

   logic [CW-1:0] w_px;
   logic [CW-1:0] w_py;
   logic [CW-1:0] w_bx;
   logic [CW-1:0] w_by;
   logic          w_in_box;

   // rising edge of the last-pixel condition: one strobe per frame
   // regardless of how many clocks each pixel lasts
   assign w_corner = (bus.o_x == X_LAST) && (bus.o_y == Y_LAST);
   assign w_eof    = w_corner && !r_corner_d;

   always_ff @(posedge clk_in) begin
      if (i_rst) begin
         r_state    <= SERVE;
         r_srv_cnt  <= '0;
         r_div_cnt  <= '0;
         r_corner_d <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_srv_cnt  <= w_srv_nxt;
         r_div_cnt  <= w_div_nxt;
         r_corner_d <= w_corner;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_srv_nxt   = r_srv_cnt;
      w_div_nxt   = r_div_cnt;
      w_move      = 1'b0;
      if (i_serve) begin
         w_state_nxt = SERVE;
         w_srv_nxt   = '0;
         w_div_nxt   = '0;
      end else begin
         unique case (r_state)
            SERVE: begin
               if (i_enable && w_eof) begin
                  if (r_srv_cnt == SRV_LAST) begin
                     w_state_nxt = RUN;
                     w_srv_nxt   = '0;
                  end else begin
                     w_srv_nxt = r_srv_cnt + 16'd1;
                  end
               end
            end
            RUN: begin
               if (!i_enable) begin
                  w_state_nxt = PAUSE;
               end else if (w_eof) begin
                  if (r_div_cnt == DIV_LAST) begin
                     w_div_nxt = '0;
                     w_move    = 1'b1;
                  end else begin
                     w_div_nxt = r_div_cnt + 16'd1;
                  end
               end
            end
            PAUSE: begin
               if (i_enable)
                  w_state_nxt = RUN;
            end
            default: w_state_nxt = SERVE;
         endcase
      end
   end

   ball_axis_step #(
      .LIMIT    (H_RES),
      .SIZE     (BALL_W),
      .INIT     (X_INIT),
      .STEP0    (STEP_X),
      .STEP_MAX (STEP_MAX),
      .PW       (10)
   ) u_x (
      .clk_in   (clk_in),
      .i_rst    (i_rst),
      .i_serve  (i_serve),
      .i_move   (w_move),
      .o_pos    (w_ball_x),
      .o_hit_lo (w_hit_l),
      .o_hit_hi (w_hit_r)
   );

   ball_axis_step #(
      .LIMIT    (V_RES),
      .SIZE     (BALL_H),
      .INIT     (Y_INIT),
      .STEP0    (STEP_Y),
      .STEP_MAX (STEP_MAX),
      .PW       (9)
   ) u_y (
      .clk_in   (clk_in),
      .i_rst    (i_rst),
      .i_serve  (i_serve),
      .i_move   (w_move),
      .o_pos    (w_ball_y),
      .o_hit_lo (w_hit_t),
      .o_hit_hi (w_hit_b)
   );

   assign w_px = CW'(bus.o_x);
   assign w_py = CW'(bus.o_y);
   assign w_bx = CW'(w_ball_x);
   assign w_by = CW'(w_ball_y);

   assign w_in_box = bus.o_active
                   && (w_px >= w_bx) && (w_px <= w_bx + BW_M1)
                   && (w_py >= w_by) && (w_py <= w_by + BH_M1);

   always_ff @(posedge clk_in) begin
      if (i_rst)
         r_color <= 1'b0;
      else
         r_color <= w_in_box;
   end

   assign bus.color    = r_color;
   assign bus.ball_x   = w_ball_x;
   assign bus.ball_y   = w_ball_y;
   assign bus.hit_edge = {w_hit_t, w_hit_b, w_hit_l, w_hit_r};

endmodule

// File: doc/ball_motion_render.md
Name: ball_motion_render

Overview:
Parametrised ball sprite for the VGA pong datapath. It keeps the ball position and direction on both axes, waits a serve delay, and then moves the ball once per N frames, bouncing off all four screen edges. Each cycle it compares the incoming raster coordinates against the ball box and drives a registered pixel-on flag to the colour mux. It reports position and edge hits to the game logic.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
BALL_W, 8, ball width in pixels
BALL_H, 8, ball height in pixels
X_INIT, 260, serve x (left edge of ball)
Y_INIT, 300, serve y (top edge of ball)
STEP_X, 5, initial x step per move (pixels)
STEP_Y, 3, initial y step per move (pixels)
STEP_MAX, 8, step ceiling (used only with the optional feature)
FRAME_DIV, 1, move once every FRAME_DIV frames (>=1)
SERVE_FRAMES, 60, frames to hold the ball still after reset or serve

Ports:
clk_in  in  1  system clock; all logic is on the rising edge
i_rst  in  1  reset, synchronous and active-high
i_enable  in  1  1 = run; 0 = freeze position (pause)
i_serve  in  1  one-cycle request to re-centre the ball and restart the serve delay
o_active  in  1  raster is in the active area
o_x  in  10  current pixel x
o_y  in  9  current pixel y
color  out  1  ball pixel-on, registered
ball_x  out  10  current ball left edge
ball_y  out  9  current ball top edge
hit_edge  out  4  one-cycle pulse {top,bottom,left,right}

Behaviour:
- Reset values:
  - color=0, hit_edge=0
  - ball_x=X_INIT, ball_y=Y_INIT
  - direction +x, +y
  - steps=STEP_X/STEP_Y
  - counters=0
  - state SERVE
- Reset wins over every other input.
- eof strobe: (o_x==H_RES-1 && o_y==V_RES-1) is true this cycle and was false last cycle. This gives exactly one strobe per frame at any pixel-clock ratio.
- Render:
  - color <= o_active && ball_x<=o_x<=ball_x+BALL_W-1 && ball_y<=o_y<=ball_y+BALL_H-1.
  - When o_active=0, color is 0; it never holds its previous value.
  - Latency is 1 cycle.
  - Comparisons are done at 11 bits, with no overflow.
- FSM:
  - SERVE:
    - Count eof strobes. When the count reaches SERVE_FRAMES, go to RUN and clear the counter.
    - i_enable=0 stalls the count.
  - RUN:
    - i_enable=0 goes to PAUSE.
    - On eof, increment the frame-divider counter. When it reaches FRAME_DIV-1, clear it and perform a move in the same cycle.
  - PAUSE:
    - Position and counters are held.
    - i_enable=1 returns to RUN with no new serve delay.
  - i_serve (any state):
    - Position goes to X_INIT/Y_INIT and steps reset.
    - Directions are kept; counters clear; state goes to SERVE.
    - i_serve wins over a coincident eof.
- Move, per axis (x shown; y identical with V_RES/BALL_H/top/bottom):
  - +dir: if ball_x+step > H_RES-BALL_W, then ball_x <= H_RES-BALL_W, dir <= -, right pulse. Else ball_x <= ball_x+step.
  - -dir: if ball_x < step, then ball_x <= 0, dir <= +, left pulse. Else ball_x <= ball_x-step.
  - Corner: both axes flip in the same cycle, and both bits are set in one hit_edge pulse.
- hit_edge is asserted for exactly the move cycle, then returns to 0.
- ball_x/ball_y update in the move cycle. Rendering uses the new position from the next cycle.

Optional Feature:
- Macro BALL_SPEEDUP_EN.
- Defined: each edge hit on an axis increments that axis step by 1, saturating at STEP_MAX. The bounce test uses the pre-increment step. Serve and reset restore STEP_X/STEP_Y.
- Undefined: steps stay constant and STEP_MAX is unused.

Decomposition:
- Package ball_pkg holds:
  - default screen constants H_RES_DEF=640, V_RES_DEF=480
  - state enum {SERVE, RUN, PAUSE}
  - direction typedef (1 bit, POS/NEG)
  - hit_edge bit indices
- One sub-module, ball_axis_step, is instantiated for x and y.
  - Parameters: axis limit, size, init, initial step, step max.
  - Function: position, direction and step registers, plus the move/bounce rule.
  - Outputs: position and a low/high hit.

Test Plan:
- Reset; then 60 eofs with i_enable=1 -> ball_x=260, ball_y=300 throughout. The first move happens on eof #61 (FRAME_DIV=1): ball_x=265, ball_y=303.
- Run 74 moves from (260,300) -> ball_x=630. The next move gives ball_x=632, dir -x, hit_edge=4'b0001 for 1 cycle. The following move gives 627.
- y axis: after 57 moves ball_y=471. The next move gives ball_y=472 with hit_edge bottom bit set. Set up a coincident x/y edge case -> single pulse with both bits set.
- Raster sweep with ball at (260,300) and o_active=1 -> color=1 exactly for x in 260..267 and y in 300..307, 1 cycle after the coordinates. With o_active=0 -> color=0.
- i_enable=0 for 10 frames mid-RUN -> position frozen, no hit pulses. Re-enable -> move on the next eof with no serve delay. i_serve on an eof cycle -> (260,300), SERVE, no move.
- Assert i_rst mid-run at (500,200) -> next cycle outputs at reset values. With BALL_SPEEDUP_EN defined: after a right bounce, x step=6; after 3 further x hits the step saturates at 8.
